led_adc_sequencer: RTL and testbench
====================================

Name: led_adc_sequencer

Overview:
- Time-multiplexes the finger-clip LEDs: infrared for one half-period, then red, repeating. Full IR+red cycle is 10 ms, i.e. 100 Hz alternation.
- In each LED phase it waits for the LED to settle, then triggers one ADC conversion through a start/done handshake.
- The 8-bit result is routed to the IR or red FIR channel, with a one-cycle valid strobe that serves as that filter's sample enable.
- Sits between the ADC interface and the two FIR filter instances; it is the only block that sequences them.

Parameters:
- HALF_PERIOD_CYC, 5000: clock cycles per LED phase (5 ms at 1 MHz CLK).
- SETTLE_CYC, 1000: phase-counter value at which adc_start is issued; must be in 1..HALF_PERIOD_CYC-2.
- DEAD_CYC, 50: LED-off cycles at the start of each phase. Used only with DEADTIME_EN; must be < SETTLE_CYC.

Ports:
- CLK, input, 1: single system clock.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: sequencer run enable.
- adc_done, input, 1: ADC conversion complete, valid for one cycle.
- adc_data, input, 8: ADC result, valid while adc_done=1.
- adc_start, output, 1: one-cycle conversion request.
- led_ir, output, 1: IR LED drive, active-high.
- led_red, output, 1: red LED drive, active-high.
- phase, output, 1: current phase, 0 = IR, 1 = red.
- ir_sample, output, 8: last captured IR sample, held between updates.
- ir_valid, output, 1: one-cycle strobe when ir_sample updates.
- red_sample, output, 8: last captured red sample, held between updates.
- red_valid, output, 1: one-cycle strobe when red_sample updates.
- adc_timeout, output, 1: sticky flag, conversion missed its phase.

Behaviour:
- Reset (rst=1 at a CLK edge): all outputs 0, FSM in IDLE, phase counter 0. rst has priority over en.
- FSM states: IDLE, SETTLE, CONV, HOLD. The phase register selects the IR or red channel.
- IDLE: LEDs off, counter held at 0. When en=1, go to SETTLE with phase=0 and counter=0.
- Phase counter counts 0..HALF_PERIOD_CYC-1 in every non-IDLE state.
  - At HALF_PERIOD_CYC-1 it wraps to 0, phase toggles, and the FSM goes to SETTLE.
- LED drive in non-IDLE states: led_ir = (phase==0), led_red = (phase==1). The two LEDs are never high together.
- SETTLE:
  - On the cycle where counter==SETTLE_CYC, adc_start=1 for exactly that cycle; next state is CONV.
- CONV:
  - adc_done=1 at an edge: adc_data is registered into the active channel's sample register.
  - The matching *_valid is high for the one cycle in which the new value is visible; next state is HOLD.
  - Latency: adc_done to sample/valid is 1 cycle.
- HOLD: wait for phase wrap.
- adc_done in IDLE, SETTLE or HOLD, or in the same cycle as adc_start, is ignored.
- Phase wrap while in CONV:
  - No capture; adc_timeout is set and stays set until rst or en=0.
  - The sample register keeps its old value and no valid is issued.
- adc_done arriving exactly on the wrap cycle while in CONV counts as a valid capture; timeout is not set.
- en falling in any state (checked at each edge):
  - Next cycle the FSM is in IDLE, LEDs are off, counter=0, adc_timeout cleared.
  - An in-flight conversion is abandoned; sample registers keep their values.
  - Re-enable always starts at the IR phase.
- ir_valid and red_valid are never high in the same cycle.
- At most one valid per channel per 2*HALF_PERIOD_CYC cycles.

Optional Feature:
- Macro: DEADTIME_EN.
- Defined: in non-IDLE states, both LEDs are 0 while counter < DEAD_CYC; the active LED turns on at counter==DEAD_CYC. This guarantees break-before-make between phases. ADC timing is unchanged.
- Undefined: the active LED is on for the full phase, including counter 0. DEAD_CYC is unused.

Test Plan:
All scenarios use HALF_PERIOD_CYC=20, SETTLE_CYC=5, DEAD_CYC=2.
- Normal cycle: rst pulse, en=1; ADC model returns done 3 cycles after start with data 0x5A (IR), then 0xA5 (red).
  - adc_start at counter 5 of each phase.
  - ir_sample=0x5A with ir_valid for 1 cycle, then red_sample=0xA5 with red_valid.
  - led_ir high for 20 cycles, then led_red for 20.
  - Repeats every 40 cycles.
- Timeout: ADC model never asserts done in the IR phase.
  - adc_timeout=1 at the wrap to red; ir_valid never pulses; ir_sample keeps its old value.
  - Red phase still samples normally.
- Boundary capture: adc_done on the wrap cycle (counter 19).
  - Sample captured, valid pulsed, adc_timeout stays 0, phase toggles normally.
- Spurious done: adc_done pulses in SETTLE (counter 2) and in HOLD.
  - No valid, samples unchanged.
- Enable drop mid-CONV: en=0 at counter 7.
  - Next cycle LEDs=0, adc_start=0, adc_timeout=0.
  - Re-assert en: first adc_start 6 cycles later (counter 0 to 5), phase=0.
- DEADTIME_EN build: led_ir and led_red both 0 at counters 0–1 of every phase, the active LED on from counter 2; never both high.

Source files
------------

// File: rtl/led_adc_sequencer.sv
// Alternates the IR and red finger-clip LEDs, triggers one ADC conversion per phase
// and routes the result to the IR or red FIR channel. Optional macro: DEADTIME_EN.
module led_adc_sequencer #(
    parameter int HALF_PERIOD_CYC = 5000,
    parameter int SETTLE_CYC      = 1000,
    parameter int DEAD_CYC        = 50
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       en,
    input  logic       adc_done,
    input  logic [7:0] adc_data,
    output logic       adc_start,
    output logic       led_ir,
    output logic       led_red,
    output logic       phase,
    output logic [7:0] ir_sample,
    output logic       ir_valid,
    output logic [7:0] red_sample,
    output logic       red_valid,
    output logic       adc_timeout
);

    localparam int CNT_W = (HALF_PERIOD_CYC > 1) ? $clog2(HALF_PERIOD_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_VAL   = CNT_W'(HALF_PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYC);

    typedef enum logic [1:0] {IDLE, SETTLE, CONV, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic             capture;
    logic             led_on;

    assign wrap    = (state != IDLE) && (cnt == LAST_VAL);
    assign capture = (state == CONV) && adc_done;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The phase wrap overrides whatever the per-state logic chose.
    always_comb begin
        state_next = state;
        adc_start  = 1'b0;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:   state_next = SETTLE;
                SETTLE: begin
                    if (cnt == SETTLE_VAL) begin
                        adc_start  = 1'b1;
                        state_next = CONV;
                    end
                end
                CONV:   begin
                    if (adc_done) begin
                        state_next = HOLD;
                    end
                end
                HOLD:    state_next = HOLD;
                default: state_next = IDLE;
            endcase
            if (wrap) begin
                state_next = SETTLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            cnt         <= '0;
            phase       <= 1'b0;
            ir_sample   <= 8'h00;
            red_sample  <= 8'h00;
            ir_valid    <= 1'b0;
            red_valid   <= 1'b0;
            adc_timeout <= 1'b0;
        end else begin
            ir_valid  <= 1'b0;
            red_valid <= 1'b0;
            if (!en || state == IDLE) begin
                cnt         <= '0;
                phase       <= 1'b0;
                adc_timeout <= 1'b0;
            end else begin
                if (capture) begin
                    if (phase) begin
                        red_sample <= adc_data;
                        red_valid  <= 1'b1;
                    end else begin
                        ir_sample <= adc_data;
                        ir_valid  <= 1'b1;
                    end
                end
                // A conversion still open when the phase ends is a missed sample.
                if (wrap) begin
                    cnt   <= '0;
                    phase <= ~phase;
                    if (state == CONV && !adc_done) begin
                        adc_timeout <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef DEADTIME_EN
    localparam logic [CNT_W-1:0] DEAD_VAL = CNT_W'(DEAD_CYC);

    always_comb begin
        led_on = (state != IDLE) && (cnt >= DEAD_VAL);
    end
`else
    logic unused_dead_cfg;
    assign unused_dead_cfg = (DEAD_CYC > 0);

    always_comb begin
        led_on = (state != IDLE);
    end
`endif

    assign led_ir  = led_on && !phase;
    assign led_red = led_on && phase;

endmodule

// File: tb/tb_led_adc_sequencer.sv
// Directed bench for led_adc_sequencer with a time-position model of the LED/ADC schedule.
module tb_led_adc_sequencer;

    localparam int HP = 20;
    localparam int S  = 5;
    localparam int DC = 2;

    logic       CLK = 1'b0;
    logic       rst;
    logic       en;
    logic       adc_done;
    logic [7:0] adc_data;
    logic       adc_start;
    logic       led_ir;
    logic       led_red;
    logic       phase;
    logic [7:0] ir_sample;
    logic       ir_valid;
    logic [7:0] red_sample;
    logic       red_valid;
    logic       adc_timeout;

    led_adc_sequencer #(
        .HALF_PERIOD_CYC(HP),
        .SETTLE_CYC     (S),
        .DEAD_CYC       (DC)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .en         (en),
        .adc_done   (adc_done),
        .adc_data   (adc_data),
        .adc_start  (adc_start),
        .led_ir     (led_ir),
        .led_red    (led_red),
        .phase      (phase),
        .ir_sample  (ir_sample),
        .ir_valid   (ir_valid),
        .red_sample (red_sample),
        .red_valid  (red_valid),
        .adc_timeout(adc_timeout)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus controls, applied by the driver shortly after each rising edge.
    logic       rst_cmd   = 1'b1;
    logic       en_cmd    = 1'b0;
    logic       resp_on   = 1'b1;
    int         resp_dly  = 3;
    int         cd        = 0;
    logic       spur_on   = 1'b0;
    logic [7:0] ir_data   = 8'h5A;
    logic [7:0] red_data  = 8'hA5;

    // Model: time since enable determines position and phase.
    logic       m_known = 1'b0;
    logic       m_run   = 1'b0;
    int         m_t     = 0;
    logic       m_cap   = 1'b0;
    logic [7:0] m_ir    = 8'h00;
    logic [7:0] m_red   = 8'h00;
    logic       m_ir_v  = 1'b0;
    logic       m_red_v = 1'b0;
    logic       m_to    = 1'b0;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge CLK) begin
        int pos;
        int ph;
        m_ir_v  = 1'b0;
        m_red_v = 1'b0;
        if (rst) begin
            m_known = 1'b1;
            m_run   = 1'b0;
            m_t     = 0;
            m_cap   = 1'b0;
            m_ir    = 8'h00;
            m_red   = 8'h00;
            m_to    = 1'b0;
        end else if (!en) begin
            m_run = 1'b0;
            m_t   = 0;
            m_cap = 1'b0;
            m_to  = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_t   = 0;
            m_cap = 1'b0;
        end else begin
            pos = m_t % HP;
            ph  = (m_t / HP) % 2;
            if (adc_done && pos > S && !m_cap) begin
                m_cap = 1'b1;
                if (ph == 1) begin
                    m_red   = adc_data;
                    m_red_v = 1'b1;
                end else begin
                    m_ir   = adc_data;
                    m_ir_v = 1'b1;
                end
            end else if (pos == HP - 1 && !m_cap) begin
                m_to = 1'b1;
            end
            m_t++;
            if (m_t % HP == 0) begin
                m_cap = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        int   pos;
        logic ph;
        logic on;
        if (m_known) begin
            pos = m_t % HP;
            ph  = m_run && ((m_t / HP) % 2 == 1);
            on  = m_run;
`ifdef DEADTIME_EN
            on  = m_run && (pos >= DC);
`endif
            check_output("adc_start", 8'(adc_start), 8'(m_run && en && pos == S));
            check_output("led_ir", 8'(led_ir), 8'(on && !ph));
            check_output("led_red", 8'(led_red), 8'(on && ph));
            check_output("phase", 8'(phase), 8'(ph));
            check_output("ir_sample", ir_sample, m_ir);
            check_output("ir_valid", 8'(ir_valid), 8'(m_ir_v));
            check_output("red_sample", red_sample, m_red);
            check_output("red_valid", 8'(red_valid), 8'(m_red_v));
            check_output("adc_timeout", 8'(adc_timeout), 8'(m_to));
        end
    end

    // Each iteration is one clock cycle; ends at that cycle's falling edge.
    task automatic apply_stimulus(input int n);
        int   pos;
        logic hit;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #2;
            rst = rst_cmd;
            en  = en_cmd;
            hit = 1'b0;
            if (cd > 0) begin
                cd--;
                hit = (cd == 0);
            end
            pos      = m_t % HP;
            adc_done = hit || (spur_on && m_run && (pos == 2 || pos == 14));
            if (hit) begin
                adc_data = ((m_t / HP) % 2 == 1) ? red_data : ir_data;
            end else begin
                adc_data = 8'hEE;
            end
            @(negedge CLK);
            if (adc_start && resp_on) begin
                cd = resp_dly;
            end
        end
    endtask

    localparam logic LED_AT_CNT0 =
`ifdef DEADTIME_EN
        1'b0;
`else
        1'b1;
`endif

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        adc_done = 1'b0;
        adc_data = 8'h00;

        apply_stimulus(3);
        check_output("rst_led_ir", 8'(led_ir), 8'h00);
        check_output("rst_ir_sample", ir_sample, 8'h00);
        check_output("rst_timeout", 8'(adc_timeout), 8'h00);

        // Normal cycle
        rst_cmd = 1'b0;
        en_cmd  = 1'b1;
        apply_stimulus(1);
        check_output("idle_led_ir", 8'(led_ir), 8'h00);
        apply_stimulus(1);
        check_output("cnt0_led_ir", 8'(led_ir), 8'(LED_AT_CNT0));
        apply_stimulus(5);
        check_output("cnt5_start", 8'(adc_start), 8'h01);
        apply_stimulus(4);
        check_output("ir_valid_cnt9", 8'(ir_valid), 8'h01);
        check_output("ir_sample_5a", ir_sample, 8'h5A);
        apply_stimulus(11);
        check_output("red_phase", 8'(phase), 8'h01);
        check_output("red_cnt0_led", 8'(led_red), 8'(LED_AT_CNT0));
        apply_stimulus(9);
        check_output("red_valid_cnt9", 8'(red_valid), 8'h01);
        check_output("red_sample_a5", red_sample, 8'hA5);
        apply_stimulus(45);

        // Timeout in the IR phase
        resp_on = 1'b0;
        apply_stimulus(6);
        apply_stimulus(19);
        check_output("to_before_wrap", 8'(adc_timeout), 8'h00);
        apply_stimulus(1);
        check_output("to_after_wrap", 8'(adc_timeout), 8'h01);
        check_output("to_ir_kept", ir_sample, 8'h5A);
        resp_on  = 1'b1;
        red_data = 8'h3C;
        apply_stimulus(9);
        check_output("to_red_valid", 8'(red_valid), 8'h01);
        check_output("to_red_sample", red_sample, 8'h3C);

        // Enable drop mid-conversion at counter 7
        apply_stimulus(17);
        en_cmd = 1'b0;
        apply_stimulus(1);
        check_output("drop_to_sticky", 8'(adc_timeout), 8'h01);
        apply_stimulus(1);
        check_output("drop_led_ir", 8'(led_ir), 8'h00);
        check_output("drop_timeout", 8'(adc_timeout), 8'h00);
        en_cmd   = 1'b1;
        resp_dly = 14;
        ir_data  = 8'h77;
        apply_stimulus(1);
        apply_stimulus(6);
        check_output("reen_start", 8'(adc_start), 8'h01);
        check_output("reen_phase", 8'(phase), 8'h00);
        check_output("reen_ir_kept", ir_sample, 8'h5A);

        // Capture on the wrap cycle
        apply_stimulus(15);
        check_output("wrap_ir_valid", 8'(ir_valid), 8'h01);
        check_output("wrap_ir_sample", ir_sample, 8'h77);
        check_output("wrap_timeout", 8'(adc_timeout), 8'h00);
        check_output("wrap_phase", 8'(phase), 8'h01);

        // Spurious done in SETTLE and HOLD
        resp_dly = 3;
        red_data = 8'h22;
        ir_data  = 8'h11;
        spur_on  = 1'b1;
        apply_stimulus(9);
        check_output("spur_red_valid", 8'(red_valid), 8'h01);
        check_output("spur_red_sample", red_sample, 8'h22);
        apply_stimulus(40);
        check_output("spur_red_sample2", red_sample, 8'h22);
        check_output("spur_ir_sample", ir_sample, 8'h11);
        apply_stimulus(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
